inst_fetch_queue: RTL and testbench

- Parametrised fetch buffer placed between the instruction-fetch stage and decode.
- Tracks in-order requests outstanding on the inst sram-like interface (req/addr_ok/data_ok), buffers returned {pc, inst, ex-info} words in a FIFO, and drives the fs2ds valid/allowin handshake.
- On a pipeline flush (exception, ertn, refetch, branch redirect) it empties itself and silently drops every response still in flight for the old path.
- Successor to the single-entry fetch buffer: depth and outstanding-request limit are parameters.

---
 rtl/inst_fetch_queue.sv | 112 +++++++++++
 tb/tb_inst_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch buffer between IF and ID: tracks outstanding inst-sram requests, buffers returned
// words in a circular FIFO and silently drops responses that belong to a flushed path.
module inst_fetch_queue #(
   parameter  int DATA_W  = 64,
   parameter  int DEPTH   = 4,
   parameter  int MAX_OUT = 2,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_issued,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              can_issue,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count,
   output logic [OUT_W-1:0]  live_out,
   output logic [OUT_W-1:0]  drop_cnt,
   output logic              proto_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = OUT_W + 2;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OUT_W-1:0]  live_q, live_d, drop_q, drop_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic pop, rsp_keep, rsp_orphan, push_ovf, push, wr_en;
   logic [SUM_W-1:0] flush_sum, live_sum;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[head_q] : '0;
   assign count     = count_q;
   assign live_out  = live_q;
   assign drop_cnt  = drop_q;
   assign proto_err = err_q;
   // Credit check: every live request already owns a FIFO slot, so a kept response never overflows.
   assign can_issue = !flush
                      && ((int'(count_q) + int'(live_q)) < DEPTH)
                      && ((int'(live_q) + int'(drop_q)) < MAX_OUT);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      live_d     = live_q;
      drop_d     = drop_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      pop        = out_valid && out_ready;
      rsp_keep   = rsp_valid && (drop_q == '0) && (live_q != '0);
      rsp_orphan = rsp_valid && (drop_q == '0) && (live_q == '0);
      push_ovf   = rsp_keep && (count_q == CNT_W'(DEPTH)) && !pop;
      push       = rsp_keep && !push_ovf;
      flush_sum  = SUM_W'(drop_q) + SUM_W'(live_q) + SUM_W'(req_issued);
      if (rsp_valid && (flush_sum != '0)) flush_sum = flush_sum - SUM_W'(1);
      live_sum   = SUM_W'(live_q) - SUM_W'(push) + SUM_W'(req_issued);

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         live_d  = '0;
         drop_d  = (flush_sum > SUM_W'(OUT_MAX)) ? OUT_MAX : flush_sum[OUT_W-1:0];
         if (rsp_orphan) err_d = 1'b1;
      end else begin
         wr_en = push;
         if (pop)  head_d = ptr_inc(head_q);
         if (push) tail_d = ptr_inc(tail_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (rsp_valid && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
         live_d = (live_sum > SUM_W'(OUT_MAX)) ? OUT_MAX : live_sum[OUT_W-1:0];
         if (rsp_orphan || (req_issued && !can_issue) || push_ovf) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
         drop_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         live_q  <= live_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   // Storage needs no reset: out_data is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem_q[tail_q] <= rsp_data;
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, hand sequences,
// and randomized legal traffic compared against a queue-based reference model.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, flush, req_issued, rsp_valid, out_ready;
   logic [63:0] rsp_data;
   logic        can_issue, out_valid, proto_err;
   logic [63:0] out_data;
   logic [2:0]  count;
   logic [1:0]  live_out, drop_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   inst_fetch_queue #(.DATA_W(64), .DEPTH(4), .MAX_OUT(2)) dut (
      .clk(clk), .reset(reset), .flush(flush), .req_issued(req_issued),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .can_issue(can_issue),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .live_out(live_out), .drop_cnt(drop_cnt), .proto_err(proto_err)
   );

   // reference model: buffered words, live/dropped outstanding counts, sticky error
   logic [63:0] mq[$];
   int          m_live, m_drop;
   bit          m_err;

   function automatic bit m_can(input bit f);
      return !f && (mq.size() + m_live < 4) && (m_live + m_drop < 2);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rst, input bit f, input bit rq, input bit rv,
                        input logic [63:0] d, input bit rdy);
      reset = rst; flush = f; req_issued = rq; rsp_valid = rv; rsp_data = d; out_ready = rdy;
   endtask

   task automatic model_update(input bit rst, input bit f, input bit rq, input bit rv,
                               input logic [63:0] d, input bit rdy);
      int s;
      bit can, pop;
      if (rst) begin
         mq.delete(); m_live = 0; m_drop = 0; m_err = 0;
      end else if (f) begin
         if (rv && m_live == 0 && m_drop == 0) m_err = 1;
         s = m_drop + m_live + int'(rq);
         if (rv && s > 0) s--;
         m_drop = (s > 3) ? 3 : s;
         m_live = 0;
         mq.delete();
      end else begin
         can = m_can(1'b0);
         pop = (mq.size() > 0) && rdy;
         if (rq && !can) m_err = 1;
         if (pop) void'(mq.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else if (m_live > 0) begin
               if (mq.size() == 4) m_err = 1;
               else begin
                  mq.push_back(d);
                  m_live--;
               end
            end else m_err = 1;
         end
         if (rq) m_live = (m_live + 1 > 3) ? 3 : m_live + 1;
      end
   endtask

   task automatic mstep(input bit rst, input bit f, input bit rq, input bit rv,
                        input logic [63:0] d, input bit rdy);
      drive(rst, f, rq, rv, d, rdy);
      #1;
      if (!rst) chk("can_issue", 64'(can_issue), 64'(m_can(f)));
      @(posedge clk);
      model_update(rst, f, rq, rv, d, rdy);
      #1;
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("live_out", 64'(live_out), 64'(m_live));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("proto_err", 64'(proto_err), 64'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) mstep(0, 0, 0, 0, 64'h0, 0);
   endtask

   typedef struct {
      bit f, rq, rv; logic [63:0] d; bit rdy;
      int cnt; bit vld; logic [63:0] dat; int live, drop; bit err;
   } vec_t;
   vec_t tbl[$];

   initial begin
      drive(1, 0, 0, 0, 64'h0, 0);
      mq.delete(); m_live = 0; m_drop = 0; m_err = 0;

      // in-order delivery, flush drop accounting, flush coinciding with a response
      //                 f  rq rv data        rdy cnt vld dat         live drop err
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       1, 0, 0});
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       2, 0, 0});
      tbl.push_back('{0, 0, 1, 64'hA0A0,   1,  1, 1, 64'hA0A0,    1, 0, 0});
      tbl.push_back('{0, 1, 1, 64'hB1B1,   1,  1, 1, 64'hB1B1,    1, 0, 0});
      tbl.push_back('{0, 0, 0, 64'h0,      1,  0, 0, 64'h0,       1, 0, 0});
      tbl.push_back('{0, 0, 1, 64'hC2C2,   1,  1, 1, 64'hC2C2,    0, 0, 0});
      tbl.push_back('{0, 0, 0, 64'h0,      1,  0, 0, 64'h0,       0, 0, 0});
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       1, 0, 0});
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       2, 0, 0});
      tbl.push_back('{1, 1, 0, 64'h0,      1,  0, 0, 64'h0,       0, 3, 0});
      tbl.push_back('{0, 0, 1, 64'hDEAD1,  1,  0, 0, 64'h0,       0, 2, 0});
      tbl.push_back('{0, 0, 1, 64'hDEAD2,  1,  0, 0, 64'h0,       0, 1, 0});
      tbl.push_back('{0, 1, 1, 64'hDEAD3,  1,  0, 0, 64'h0,       1, 0, 0});
      tbl.push_back('{0, 0, 1, 64'hD3D3,   0,  1, 1, 64'hD3D3,    0, 0, 0});
      tbl.push_back('{0, 0, 0, 64'h0,      1,  0, 0, 64'h0,       0, 0, 0});
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       1, 0, 0});
      tbl.push_back('{1, 0, 0, 64'h0,      1,  0, 0, 64'h0,       0, 1, 0});
      tbl.push_back('{0, 1, 0, 64'h0,      1,  0, 0, 64'h0,       1, 1, 0});
      tbl.push_back('{1, 0, 1, 64'hDEAD4,  1,  0, 0, 64'h0,       0, 1, 0});
      tbl.push_back('{0, 0, 1, 64'hDEAD5,  1,  0, 0, 64'h0,       0, 0, 0});
      tbl.push_back('{0, 0, 0, 64'h0,      1,  0, 0, 64'h0,       0, 0, 0});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_err", 64'(proto_err), 64'h0);

      foreach (tbl[i]) begin
         drive(0, tbl[i].f, tbl[i].rq, tbl[i].rv, tbl[i].d, tbl[i].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("vec%0d_data", i), out_data, tbl[i].dat);
         chk($sformatf("vec%0d_live", i), 64'(live_out), 64'(tbl[i].live));
         chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
         chk($sformatf("vec%0d_err", i), 64'(proto_err), 64'(tbl[i].err));
      end

      // fill to DEPTH with decode stalled, then release one entry and drain across the wrap
      mstep(1, 0, 0, 0, 64'h0, 0);
      for (int i = 0; i < 12; i++)
         mstep(0, 0, m_can(0), m_live > 0, 64'h100 + 64'(i), 0);
      drive(0, 0, 0, 0, 64'h0, 0);
      #1;
      chk("full_count", 64'(count), 64'h4);
      chk("full_can_issue", 64'(can_issue), 64'h0);
      mstep(0, 0, 0, 0, 64'h0, 1);
      #1;
      chk("after_pop_can_issue", 64'(can_issue), 64'h1);
      for (int i = 0; i < 16; i++)
         mstep(0, 0, m_can(0), m_live > 0, 64'h200 + 64'(i), i % 3 != 0);
      idle(1);
      for (int i = 0; i < 6; i++) mstep(0, 0, 0, 0, 64'h0, 1);

      // orphan response and illegal issue both set the sticky error
      mstep(1, 0, 0, 0, 64'h0, 0);
      mstep(0, 0, 0, 1, 64'h5, 0);
      chk("orphan_err", 64'(proto_err), 64'h1);
      idle(3);
      chk("err_sticky", 64'(proto_err), 64'h1);
      mstep(1, 0, 0, 0, 64'h0, 0);
      chk("err_cleared", 64'(proto_err), 64'h0);
      mstep(0, 0, 1, 0, 64'h0, 0);
      mstep(0, 0, 1, 0, 64'h0, 0);
      mstep(0, 0, 1, 0, 64'h0, 0);
      chk("illegal_req_err", 64'(proto_err), 64'h1);

      // reset in the middle of traffic, then a stale response
      mstep(1, 0, 0, 0, 64'h0, 0);
      mstep(0, 0, 1, 0, 64'h0, 0);
      mstep(0, 0, 1, 1, 64'h301, 0);
      mstep(0, 0, 1, 1, 64'h302, 0);
      mstep(0, 0, 1, 1, 64'h303, 0);
      chk("pre_rst_count", 64'(count), 64'h3);
      mstep(1, 0, 1, 1, 64'h304, 1);
      chk("midrst_count", 64'(count), 64'h0);
      chk("midrst_live", 64'(live_out), 64'h0);
      chk("midrst_valid", 64'(out_valid), 64'h0);
      chk("midrst_data", out_data, 64'h0);
      mstep(0, 0, 0, 1, 64'h305, 0);
      chk("stale_rsp_err", 64'(proto_err), 64'h1);

      // randomized legal traffic
      mstep(1, 0, 0, 0, 64'h0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit f, rq, rv, rdy, rst;
         rst = ($urandom_range(0, 499) == 0);
         f   = ($urandom_range(0, 19) == 0);
         rq  = m_can(f) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (f && $urandom_range(0, 3) == 0) rq = 1'b1;
         rv  = (m_live + m_drop > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         rdy = 1'($urandom_range(0, 1));
         mstep(rst, f, rq, rv, {$urandom, $urandom}, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
